// File: rtl/output_writer_layer2.sv
// Purpose: packs the flat layer-2 score vector into BRAM, one element per
//          cycle from BASE_ADDR, then optionally reads it back and counts errors.
// Latency: done rises 2N+3 cycles after start (VERIFY=1), N+1 cycles (VERIFY=0).
// Backpressure: none; start is taken only in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - run request, sampled in IDLE and DONE only
//   data_in         - N elements, element i = data_in[i*W +: W]
//   bram_en/ren/wen - registered BRAM controls
//   bram_addr/din   - registered BRAM address and write data
//   bram_dout       - BRAM read data, valid two cycles after a read address
//   busy            - high while writing or verifying
//   done            - level, high while parked in DONE
//   mismatch_count  - read-back errors of the most recent run

module output_writer_layer2 #(
  parameter int N          = 10,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int BASE_ADDR  = 1300,
  parameter int VERIFY     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N*W-1:0]           data_in,
  output logic                     bram_en,
  output logic                     bram_ren,
  output logic                     bram_wen,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  output logic [W-1:0]             bram_din,
  input  logic [W-1:0]             bram_dout,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N+1)-1:0]   mismatch_count
);

  // Phase counter must reach N+1: the verify phase has N read cycles plus
  // two trailing cycles waiting for the last read data.
  localparam int CW = $clog2(N + 2);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = $clog2(N + 1);

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_A   = ADDR_WIDTH'(BASE_ADDR + N - 1);
  localparam logic [CW-1:0]         WR_LAST  = CW'(N - 1);
  localparam logic [CW-1:0]         VF_LAST  = CW'(N + 1);
  localparam logic [CW-1:0]         RD_COUNT = CW'(N);
  localparam logic [MW-1:0]         MM_MAX   = MW'(N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [W-1:0]            elem_q [N];
  logic [W-1:0]            elem_d [N];
  logic [MW-1:0]           mm_q, mm_d;

  logic                    bram_en_q, bram_en_d;
  logic                    bram_ren_q, bram_ren_d;
  logic                    bram_wen_q, bram_wen_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [W-1:0]            bram_din_q, bram_din_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Index of the element whose read data arrives this cycle; only meaningful
  // when cnt_q >= 2 in VERIFY.
  logic [IW-1:0]           chk_idx;
  assign chk_idx = IW'(cnt_q - CW'(2));

  // Next-state, counters and latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    elem_d  = elem_q;
    mm_d    = mm_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          for (int i = 0; i < N; i++) begin
            elem_d[i] = data_in[i*W +: W];
          end
          mm_d    = '0;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = (VERIFY != 0) ? ST_VERIFY : ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_VERIFY: begin
        // Read k was issued in verify cycle k; its data is here in cycle k+2.
        if (cnt_q >= CW'(2)) begin
          if ((bram_dout != elem_q[chk_idx]) && (mm_q != MM_MAX)) begin
            mm_d = mm_q + MW'(1);
          end
        end
        if (cnt_q == VF_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are derived from the next state so that they line up
  // with the cycle the state machine is entering.
  always_comb begin
    bram_en_d   = 1'b0;
    bram_ren_d  = 1'b0;
    bram_wen_d  = 1'b0;
    bram_addr_d = BASE_A;
    bram_din_d  = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_d)
      ST_WRITE: begin
        bram_en_d   = 1'b1;
        bram_wen_d  = 1'b1;
        bram_addr_d = BASE_A + ADDR_WIDTH'(cnt_d);
        bram_din_d  = elem_d[IW'(cnt_d)];
        busy_d      = 1'b1;
      end

      ST_VERIFY: begin
        // Enable stays up through the two drain cycles so the port keeps
        // producing the outstanding read data.
        bram_en_d = 1'b1;
        busy_d    = 1'b1;
        if (cnt_d < RD_COUNT) begin
          bram_ren_d  = 1'b1;
          bram_addr_d = BASE_A + ADDR_WIDTH'(cnt_d);
        end else begin
          bram_addr_d = LAST_A;
        end
      end

      ST_DONE: begin
        done_d = 1'b1;
      end

      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mm_q        <= '0;
      for (int i = 0; i < N; i++) begin
        elem_q[i] <= '0;
      end
      bram_en_q   <= 1'b0;
      bram_ren_q  <= 1'b0;
      bram_wen_q  <= 1'b0;
      bram_addr_q <= BASE_A;
      bram_din_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mm_q        <= mm_d;
      for (int i = 0; i < N; i++) begin
        elem_q[i] <= elem_d[i];
      end
      bram_en_q   <= bram_en_d;
      bram_ren_q  <= bram_ren_d;
      bram_wen_q  <= bram_wen_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bram_en        = bram_en_q;
  assign bram_ren       = bram_ren_q;
  assign bram_wen       = bram_wen_q;
  assign bram_addr      = bram_addr_q;
  assign bram_din       = bram_din_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch_count = mm_q;

endmodule

// File: tb/tb_output_writer_layer2.sv
// Bench for output_writer_layer2: a BRAM model with per-address corruption,
// expected BRAM events queued at stimulus time, and a monitor popping them.
module tb_output_writer_layer2;
  localparam int N    = 10;
  localparam int W    = 8;
  localparam int AW   = 11;
  localparam int BASE = 1300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, start_nv;
  logic [N*W-1:0]  data_in, data_in_nv;
  logic            bram_en, bram_ren, bram_wen, busy, done;
  logic [AW-1:0]   bram_addr;
  logic [W-1:0]    bram_din, bram_dout;
  logic [3:0]      mismatch_count;

  logic            en_nv, ren_nv, wen_nv, busy_nv, done_nv;
  logic [AW-1:0]   addr_nv;
  logic [W-1:0]    din_nv;
  logic [W-1:0]    dout_nv;
  logic [3:0]      mm_nv;

  output_writer_layer2 dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .bram_en(bram_en), .bram_ren(bram_ren), .bram_wen(bram_wen),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .busy(busy), .done(done), .mismatch_count(mismatch_count)
  );

  output_writer_layer2 #(.VERIFY(0)) dut_nv (
    .clk(clk), .rst(rst), .start(start_nv), .data_in(data_in_nv),
    .bram_en(en_nv), .bram_ren(ren_nv), .bram_wen(wen_nv),
    .bram_addr(addr_nv), .bram_din(din_nv), .bram_dout(dout_nv),
    .busy(busy_nv), .done(done_nv), .mismatch_count(mm_nv)
  );

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  // BRAM model: two-cycle read latency, optional LSB flip per address.
  logic [7:0] mem [2048];
  logic       corrupt [2048];
  logic [7:0] rd_pipe;
  always @(posedge clk) begin
    if (bram_en && bram_wen) mem[bram_addr] <= bram_din;
    if (bram_en && bram_ren) rd_pipe <= mem[bram_addr] ^ {7'b0, corrupt[bram_addr]};
    bram_dout <= rd_pipe;
  end

  typedef struct {int t; int a; int b;} ev_t;
  ev_t q_wr[$], q_rd[$], q_done[$], q_wr_nv[$], q_done_nv[$];
  int n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (tick %0d)", nm, act, exp, tick);
    end
  endtask

  task automatic unexpected(input string nm, input int a);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event at tick %0d addr %0d, required none", nm, tick, a);
  endtask

  task automatic monitor();
    int   busy_cnt = 0, last_run = 0, busy_cnt_nv = 0, last_run_nv = 0;
    logic done_prev = 1'b0, done_prev_nv = 1'b0;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (bram_en && bram_wen) begin
        if (q_wr.size() == 0) unexpected("write", int'(bram_addr));
        else begin
          e = q_wr.pop_front();
          check("wr_cycle", tick, e.t);
          check("wr_addr", int'(bram_addr), e.a);
          check("wr_din", int'(bram_din), e.b);
          check("wr_ren_low", int'(bram_ren), 0);
        end
      end
      if (bram_ren) begin
        if (q_rd.size() == 0) unexpected("read", int'(bram_addr));
        else begin
          e = q_rd.pop_front();
          check("rd_cycle", tick, e.t);
          check("rd_addr", int'(bram_addr), e.a);
          check("rd_en", int'(bram_en), 1);
        end
      end
      if (busy) busy_cnt++;
      else if (busy_cnt != 0) begin last_run = busy_cnt; busy_cnt = 0; end
      if (done && !done_prev) begin
        if (q_done.size() == 0) unexpected("done", 0);
        else begin
          e = q_done.pop_front();
          check("done_cycle", tick, e.t);
          check("busy_len", last_run, e.a);
          check("done_mm", int'(mismatch_count), e.b);
          check("done_en_low", int'(bram_en), 0);
        end
      end
      done_prev = done;

      if (en_nv && wen_nv) begin
        if (q_wr_nv.size() == 0) unexpected("nv_write", int'(addr_nv));
        else begin
          e = q_wr_nv.pop_front();
          check("nv_wr_cycle", tick, e.t);
          check("nv_wr_addr", int'(addr_nv), e.a);
          check("nv_wr_din", int'(din_nv), e.b);
        end
      end
      if (ren_nv) unexpected("nv_read", int'(addr_nv));
      if (busy_nv) busy_cnt_nv++;
      else if (busy_cnt_nv != 0) begin last_run_nv = busy_cnt_nv; busy_cnt_nv = 0; end
      if (done_nv && !done_prev_nv) begin
        if (q_done_nv.size() == 0) unexpected("nv_done", 0);
        else begin
          e = q_done_nv.pop_front();
          check("nv_done_cycle", tick, e.t);
          check("nv_busy_len", last_run_nv, e.a);
          check("nv_done_mm", int'(mm_nv), e.b);
        end
      end
      done_prev_nv = done_nv;
    end
  endtask

  function automatic logic [N*W-1:0] mk(input int b);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(b + i);
    return v;
  endfunction

  task automatic check_reset_vals();
    check("rst_en", int'(bram_en), 0);
    check("rst_ren", int'(bram_ren), 0);
    check("rst_wen", int'(bram_wen), 0);
    check("rst_addr", int'(bram_addr), BASE);
    check("rst_din", int'(bram_din), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mm", int'(mismatch_count), 0);
  endtask

  task automatic wait_done(input bit nv);
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (nv ? done_nv : done) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done within 80 cycles, required done");
    end
  endtask

  // One full VERIFY=1 run. With hold=1, start stays high until cycle 2N+2 and
  // data_in is changed at cycle 3; neither may affect the run.
  task automatic run(input logic [N*W-1:0] d, input int exp_mm, input bit hold);
    int t0;
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    t0      = tick;
    for (int i = 0; i < N; i++) begin
      q_wr.push_back('{t0 + 1 + i, BASE + i, int'(d[i*W +: W])});
      q_rd.push_back('{t0 + N + 1 + i, BASE + i, 0});
    end
    q_done.push_back('{t0 + 2*N + 3, 2*N + 2, exp_mm});
    @(negedge clk);
    check("mm_clear_at_latch", int'(mismatch_count), 0);
    check("busy_cycle1", int'(busy), 1);
    check("done_cycle1", int'(done), 0);
    if (!hold) start = 1'b0;
    else begin
      repeat (2) @(negedge clk);
      data_in = ~d;
      repeat (19) @(negedge clk);
      start = 1'b0;
    end
    wait_done(1'b0);
    repeat (2) @(negedge clk);
    check("done_hold", int'(done), 1);
    check("mm_hold", int'(mismatch_count), exp_mm);
  endtask

  task automatic run_nv(input logic [N*W-1:0] d);
    int t0;
    @(negedge clk);
    data_in_nv = d;
    start_nv   = 1'b1;
    t0         = tick;
    for (int i = 0; i < N; i++)
      q_wr_nv.push_back('{t0 + 1 + i, BASE + i, int'(d[i*W +: W])});
    q_done_nv.push_back('{t0 + N + 1, N, 0});
    @(negedge clk);
    start_nv = 1'b0;
    wait_done(1'b1);
  endtask

  task automatic run_reset_mid(input logic [N*W-1:0] d);
    int t0;
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    t0      = tick;
    for (int i = 0; i < 5; i++)
      q_wr.push_back('{t0 + 1 + i, BASE + i, int'(d[i*W +: W])});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tick", tick, t0 + 6);
    check_reset_vals();
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) corrupt[a] = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    start_nv   = 1'b0;
    data_in    = '0;
    data_in_nv = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    check("nv_rst_addr", int'(addr_nv), BASE);
    check("nv_rst_done", int'(done_nv), 0);

    run(mk(1), 0, 1'b0);
    corrupt[1305] = 1'b1;
    run(mk(1), 1, 1'b0);
    for (int a = BASE; a < BASE + N; a++) corrupt[a] = 1'b1;
    run(mk(8'h30), 10, 1'b0);
    for (int a = BASE; a < BASE + N; a++) corrupt[a] = 1'b0;
    run(mk(8'h50), 0, 1'b0);
    run(mk(8'h70), 0, 1'b1);
    run_nv(mk(8'h11));
    run_reset_mid(mk(8'h90));
    run(mk(8'hB0), 0, 1'b0);

    repeat (5) @(negedge clk);
    check("wr_left", q_wr.size(), 0);
    check("rd_left", q_rd.size(), 0);
    check("done_left", q_done.size(), 0);
    check("nv_wr_left", q_wr_nv.size(), 0);
    check("nv_done_left", q_done_nv.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
